// File: rtl/sound_pkg.sv
// Shared types, note timing table and jingle ROM for the Simon speaker arbiter.
package sound_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned HALF_W = 11;
  localparam int unsigned NOTES  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned PEND_W = 3;

  typedef logic [CODE_W-1:0] note_code_t;
  typedef note_code_t [NOTES-1:0] jingle_t;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_BTN  = 3'd1,
    SRC_HS   = 3'd2,
    SRC_WIN  = 3'd3,
    SRC_LOSE = 3'd4
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TONE   = 2'd1,
    ST_JINGLE = 2'd2
  } state_t;

  // Element 0 is the first note played.
  localparam jingle_t JINGLE_WIN  = {3'd7, 3'd7, 3'd6, 3'd5};
  localparam jingle_t JINGLE_LOSE = {3'd1, 3'd1, 3'd2, 3'd3};
  localparam jingle_t JINGLE_HS   = {3'd5, 3'd7, 3'd5, 3'd7};

  // Half-period of a note in prescaler ticks; 0 for a rest.
  function automatic logic [HALF_W-1:0] half_period(input note_code_t code);
    case (code)
      3'd1:    half_period = 11'd1776;
      3'd2:    half_period = 11'd1493;
      3'd3:    half_period = 11'd1185;
      3'd4:    half_period = 11'd888;
      3'd5:    half_period = 11'd747;
      3'd6:    half_period = 11'd593;
      3'd7:    half_period = 11'd498;
      default: half_period = 11'd0;
    endcase
  endfunction

  function automatic jingle_t jingle_rom(input src_t src);
    case (src)
      SRC_WIN:  jingle_rom = JINGLE_WIN;
      SRC_LOSE: jingle_rom = JINGLE_LOSE;
      SRC_HS:   jingle_rom = JINGLE_HS;
      default:  jingle_rom = '0;
    endcase
  endfunction

  // Owner as {lose,win,hs,button}.
  function automatic logic [3:0] src_onehot(input src_t src);
    case (src)
      SRC_BTN:  src_onehot = 4'b0001;
      SRC_HS:   src_onehot = 4'b0010;
      SRC_WIN:  src_onehot = 4'b0100;
      SRC_LOSE: src_onehot = 4'b1000;
      default:  src_onehot = 4'b0000;
    endcase
  endfunction

  // Pending-flag bit of a jingle owner as {lose,win,hs}.
  function automatic logic [PEND_W-1:0] src_pend_mask(input src_t src);
    case (src)
      SRC_HS:   src_pend_mask = 3'b001;
      SRC_WIN:  src_pend_mask = 3'b010;
      SRC_LOSE: src_pend_mask = 3'b100;
      default:  src_pend_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: prescaler ticks count out the half-period of the current note.
module tone_gen
  import sound_pkg::*;
#(
  parameter int unsigned HALF_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  note_code_t code,
  output logic       spk
);

  localparam int unsigned PRE_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] half_last;
  logic              spk_q, spk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      half_q <= '0;
      spk_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      half_q <= half_d;
      spk_q  <= spk_d;
    end
  end

  // A rest holds everything at zero, same as a restart.
  always_comb begin
    pre_d     = pre_q;
    half_d    = half_q;
    spk_d     = spk_q;
    half_last = half_period(code) - 11'd1;
    if (restart || (code == '0)) begin
      pre_d  = '0;
      half_d = '0;
      spk_d  = 1'b0;
    end else if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (half_q == half_last) begin
        half_d = '0;
        spk_d  = ~spk_q;
      end else begin
        half_d = half_q + 11'd1;
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  assign spk = spk_q;

endmodule

// File: rtl/sound_arbiter.sv
// Shares the speaker between the button echo and the WIN/LOSE/HS jingles by fixed priority.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int unsigned HALF_DIV    = 64,
  parameter int unsigned NOTE_CYCLES = 7500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_req,
  input  logic [1:0] tone_sel,
  input  logic       win_req,
  input  logic       lose_req,
  input  logic       hs_req,
  output logic       spk,
  output logic [3:0] active,
  output logic       busy
);

  localparam int unsigned NCNT_W = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam logic [NCNT_W-1:0] NOTE_LAST = NCNT_W'(NOTE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NOTES - 1);

  state_t            state_q, state_d;
  src_t              owner_q, owner_d;
  src_t              top_src;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NCNT_W-1:0] cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W-1:0] req_vec, playing, pend_clr;
  note_code_t        code_q, code_d;
  logic [3:0]        active_q;
  logic              busy_q;
  logic              restart;
  logic              launch;
  jingle_t           notes;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= SRC_NONE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      code_q   <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      code_q   <= code_d;
      active_q <= src_onehot(owner_d);
      busy_q   <= (state_d == ST_JINGLE) | (|pend_d);
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    restart  = 1'b0;
    launch   = 1'b0;
    pend_clr = '0;
    notes    = '0;

    if (pend_q[2])      top_src = SRC_LOSE;
    else if (pend_q[1]) top_src = SRC_WIN;
    else if (pend_q[0]) top_src = SRC_HS;
    else                top_src = SRC_NONE;

    // Enum order is priority order, so one compare covers both idle and preemption.
    case (state_q)
      ST_IDLE: begin
        if (top_src != SRC_NONE) begin
          launch = 1'b1;
        end else if (tone_req) begin
          state_d = ST_TONE;
          owner_d = SRC_BTN;
          code_d  = {1'b0, tone_sel} + 3'd1;
          restart = 1'b1;
        end
      end
      ST_TONE: begin
        if (top_src != SRC_NONE) begin
          launch = 1'b1;
        end else if (!tone_req) begin
          state_d = ST_IDLE;
          owner_d = SRC_NONE;
          code_d  = '0;
          restart = 1'b1;
        end else begin
          code_d  = {1'b0, tone_sel} + 3'd1;
          restart = (code_d != code_q);
        end
      end
      ST_JINGLE: begin
        if (top_src > owner_q) begin
          launch = 1'b1;
        end else if (cnt_q == NOTE_LAST) begin
          if (idx_q == IDX_LAST) begin
            if (top_src != SRC_NONE) begin
              launch = 1'b1;
            end else begin
              state_d = ST_IDLE;
              owner_d = SRC_NONE;
              idx_d   = '0;
              cnt_d   = '0;
              code_d  = '0;
              restart = 1'b1;
            end
          end else begin
            notes   = jingle_rom(owner_q);
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = '0;
            code_d  = notes[idx_d];
            restart = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + NCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = SRC_NONE;
        code_d  = '0;
        restart = 1'b1;
      end
    endcase

    if (launch) begin
      notes    = jingle_rom(top_src);
      state_d  = ST_JINGLE;
      owner_d  = top_src;
      idx_d    = '0;
      cnt_d    = '0;
      code_d   = notes[0];
      restart  = 1'b1;
      pend_clr = src_pend_mask(top_src);
    end
  end

  // Requests for the jingle already playing or already pending are dropped.
  always_comb begin
    req_vec = {lose_req, win_req, hs_req};
    playing = (state_q == ST_JINGLE) ? src_pend_mask(owner_q) : '0;
    pend_d  = (pend_q & ~pend_clr) | (req_vec & ~pend_q & ~playing);
  end

  tone_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_tone_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .code   (code_d),
    .spk    (spk)
  );

  assign active = active_q;
  assign busy   = busy_q;

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
Owns the single speaker pin of the Simon game and shares it between four requesters.
- Requesters: live button-tone echo, win jingle, lose jingle, high-score jingle.
- Arbitrates by fixed priority, sequences each jingle's fixed note list, and drives a square-wave tone generator.
- Sits beside the game controller and consumes copies of its button output/enable and its WIN, LOSE and HS flags.

Parameters:
- HALF_DIV, 64, clock cycles per tone-prescaler tick (781.25 kHz tick at 50 MHz).
- NOTE_CYCLES, 7500000, clock cycles per jingle note (150 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tone_req  input  1  level: a button tone is requested
- tone_sel  input  2  button index 0..3 for the button tone
- win_req  input  1  single-cycle pulse: play WIN jingle
- lose_req  input  1  single-cycle pulse: play LOSE jingle
- hs_req  input  1  single-cycle pulse: play HS jingle
- spk  output  1  square-wave speaker drive
- active  output  4  one-hot current owner {lose,win,hs,button}; 0 = silent
- busy  output  1  high while any jingle is playing or pending

Behaviour:
- Reset, synchronous on the clk edge and valid mid-operation: spk=0, active=0, busy=0, all pending flags cleared, FSM in IDLE, all counters 0.
- Note codes are 3 bits. Code 0 is a rest (spk held 0).
  - Codes 1..4 are button tones 0..3, with half-periods in prescaler ticks of 1776, 1493, 1185, 888.
  - Codes 5..7 have half-periods of 747, 593, 498.
- Jingles are 4 notes each:
  - WIN = 5,6,7,7
  - LOSE = 3,2,1,1
  - HS = 7,5,7,5
- Request latching:
  - A *_req pulse sets the matching pending flag.
  - A request for the jingle currently playing, or already pending, has no effect.
- Priority: LOSE > WIN > HS > button.
- FSM states: IDLE, TONE, JINGLE.
- IDLE:
  - Any pending flag set → JINGLE on the highest pending next cycle; that flag is cleared and its active bit set.
  - Otherwise, tone_req=1 → TONE.
- TONE:
  - active=0001; plays the code tone_sel+1.
  - A change of tone_sel restarts the tone phase.
  - tone_req=0 → IDLE next cycle, with spk forced 0.
  - Any pending jingle preempts TONE and takes the JINGLE path the next cycle.
- JINGLE:
  - Note index 0..3; each note lasts exactly NOTE_CYCLES clocks.
  - When note 3 expires, choose the highest remaining pending jingle and start its note 0 on the next cycle; if none, → IDLE.
  - Button requests are ignored (not queued) while in JINGLE.
- Preemption:
  - A pending jingle of higher priority than the playing one aborts it at once; the new jingle's note 0 starts the next cycle.
  - The aborted jingle is dropped, not resumed.
  - Lower-priority requests stay pending.
- Simultaneous requests: all are latched in the same cycle and play in priority order, back-to-back.
- Tone generator:
  - Every note start or owner change resets the prescaler, the half-period counter and spk to 0.
  - The first spk toggle comes exactly entry*HALF_DIV cycles after the restart, then repeats every entry*HALF_DIV cycles.
- busy = (state==JINGLE) | any pending.
- active updates the same cycle the FSM state changes.
- Width rules:
  - Half-period counter: 11 bits.
  - Prescaler: $clog2(HALF_DIV) bits.
  - Note counter: $clog2(NOTE_CYCLES) bits.
  - No counter wraps in normal use; each is compared for equality to its terminal count and then cleared.

Decomposition:
- sound_pkg holds:
  - the note-code typedef (3-bit);
  - the half-period lookup function;
  - the jingle ROM as constants JINGLE_WIN, JINGLE_LOSE, JINGLE_HS (4×3 bits each);
  - the owner enum {SRC_NONE, SRC_BTN, SRC_HS, SRC_WIN, SRC_LOSE}.
- One sub-module, tone_gen: inputs clk, rst, restart, code; output spk. It contains the prescaler, the half-period counter and the toggle flop.

Test Plan:
All scenarios use HALF_DIV=1 and NOTE_CYCLES=4000.
1. Hold rst=1 while tone_req=1 → spk=0, active=0, busy=0. Release, with tone_sel=3 → active=0001 next cycle; spk first rises 888 cycles later and then toggles every 888 cycles.
2. win_req pulse from IDLE → active=0100 and busy=1. The note sequence runs with half-periods 747, 593, 498, 498, each lasting 4000 cycles. After 16000 cycles → active=0, busy=0, spk=0.
3. hs_req and win_req pulse in the same cycle → WIN plays first (16000 cycles), then HS starts the next cycle (active=0010) with half-periods 498, 747, 498, 747.
4. HS playing; lose_req at note 1 → next cycle active=1000 and LOSE note 0 starts (half-period 1185); HS never resumes.
5. WIN playing; a second win_req and tone_req=1 → no restart and no button tone; button tone resumes only after WIN ends, if tone_req is still high.
6. rst pulsed mid-jingle with HS pending → next cycle everything is idle and the pending HS is lost.
